// File: rtl/addsub_pkg.sv
// Shared types for the pipelined adder/subtractor: op encoding and the result flag bundle.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic c_out;
    logic overflow;
    logic zero;
  } flags_t;

endpackage : addsub_pkg

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub: valid/ready in, valid/ready out.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
) ();
  import addsub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             overflow;
  logic             zero;

  // Producer/consumer side (testbench or upstream logic).
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, s, c_out, overflow, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, s, c_out, overflow, zero
  );

endinterface : pipelined_addsub_if

// File: rtl/addsub_chunk.sv
// One pipeline stage's ripple adder over a CW-bit slice; also exposes the carry into the slice MSB.
module addsub_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  output logic [CW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_cmsb
);

  logic [CW:0] w_carry;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    w_carry    = '0;
    o_sum      = '0;
    w_carry[0] = i_cin;
    // NOTE: blocking assignments are intended here; each bit must see the carry just computed below it.
    for (int i = 0; i < CW; i++) begin
      o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
      w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_carry[CW];
  assign o_cmsb = w_carry[CW-1];

endmodule : addsub_chunk

// File: rtl/pipelined_addsub.sv
// STAGES-deep pipelined add/subtract with carry chain split into equal chunks and skewed operands.
// Optional macro ADDSUB_SATURATE_EN clamps s to the signed range on overflow.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (WIDTH < 4 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be >= 4 and divisible by STAGES");
  end

  logic             w_stall;
  logic             w_advance;
  logic [STAGES-1:0] w_valid_in;
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_cout;
  logic              w_cmsb     [STAGES];
  logic [WIDTH-1:0]  w_a_in     [STAGES];
  logic [WIDTH-1:0]  w_b_in     [STAGES];
  logic [WIDTH-1:0]  w_sum_in   [STAGES];
  logic [WIDTH-1:0]  w_sum_next [STAGES];
  logic [CW-1:0]     w_sum_chunk[STAGES];

  // Stage k holds: sum bits of chunks 0..k, operands (b already inverted for
  // subtract) still waiting for higher stages, and the carry out of chunk k.
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic              r_cmsb;
  logic [WIDTH-1:0]  r_a  [STAGES];
  logic [WIDTH-1:0]  r_b  [STAGES];
  logic [WIDTH-1:0]  r_sum[STAGES];

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_s;
  flags_t           w_flags;

  // The whole pipe moves as one; bubbles travel with it and are never squeezed out.
  assign w_stall   = r_valid[LAST] && !bus.out_ready;
  assign w_advance = !w_stall;

  always_comb begin
    w_valid_in[0] = bus.in_valid;
    w_a_in[0]     = bus.a;
    w_b_in[0]     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    w_cin[0]      = (bus.op == OP_SUB);
    w_sum_in[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_valid_in[k] = r_valid[k-1];
      w_a_in[k]     = r_a[k-1];
      w_b_in[k]     = r_b[k-1];
      w_cin[k]      = r_carry[k-1];
      w_sum_in[k]   = r_sum[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    addsub_chunk #(
      .CW (CW)
    ) u_chunk (
      .i_a    (w_a_in[k][k*CW +: CW]),
      .i_b    (w_b_in[k][k*CW +: CW]),
      .i_cin  (w_cin[k]),
      .o_sum  (w_sum_chunk[k]),
      .o_cout (w_cout[k]),
      .o_cmsb (w_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_sum_next[k]              = w_sum_in[k];
      w_sum_next[k][k*CW +: CW]  = w_sum_chunk[k];
    end
  end

  // NOTE: the stage arrays are plain flops, not RAM, so resetting them is cheap and keeps reset-state outputs at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_carry <= '0;
      r_cmsb  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_advance) begin
      r_valid <= w_valid_in;
      r_carry <= w_cout;
      r_cmsb  <= w_cmsb[LAST];
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_sum[k] <= w_sum_next[k];
      end
    end
  end

  assign w_raw = r_sum[LAST];

  // Flags come straight off the last stage's registers, so they hold with the pipe.
  always_comb begin
    w_s              = w_raw;
    w_flags.c_out    = r_carry[LAST];
    w_flags.overflow = r_cmsb ^ r_carry[LAST];
`ifdef ADDSUB_SATURATE_EN
    // A wrapped result with MSB set means the true value overflowed upward.
    if (w_flags.overflow) begin
      w_s = w_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`else
    w_s = w_raw;
`endif
    w_flags.zero = r_valid[LAST] && (w_s == '0);
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_valid[LAST];
  assign bus.s         = w_s;
  assign bus.c_out     = w_flags.c_out;
  assign bus.overflow  = w_flags.overflow;
  assign bus.zero      = w_flags.zero;

endmodule : pipelined_addsub

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=32, STAGES=4): directed corners, random stream, mid-flight reset.
module tb_pipelined_addsub;
  import addsub_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
`ifdef ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] s;
    flags_t           f;
    int               acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_addsub #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t             sb[$];
  exp_t             drv_exp;
  int               n_tests = 0;
  int               n_fail  = 0;
  int               cyc     = 0;
  bit               lat_mode;
  bit               acc_now;
  bit               prev_stall;
  logic [WIDTH-1:0] snap_s;
  logic [2:0]       snap_f;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(op_e op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    exp_t         e;
    logic [WIDTH:0] full;
    logic         ov;
    if (op == OP_SUB) begin
      full = {1'b0, a} + {1'b0, ~b} + 33'd1;
      ov   = (a[WIDTH-1] != b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      ov   = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    end
    e.s          = full[WIDTH-1:0];
    e.f.c_out    = full[WIDTH];
    e.f.overflow = ov;
    if (SAT && ov) e.s = a[WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    e.f.zero = (e.s == '0);
    e.acc    = 0;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  // One clock: evaluate handshakes at the negedge, then move to just past the next posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc_now = 1'b0;
    check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
    if (prev_stall) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_s", bus.s, snap_s);
      check("hold_flags", {bus.c_out, bus.overflow, bus.zero}, snap_f);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("s", bus.s, e.s);
        check("c_out", bus.c_out, e.f.c_out);
        check("overflow", bus.overflow, e.f.overflow);
        check("zero", bus.zero, e.f.zero);
        if (lat_mode) check("latency", cyc - e.acc, STAGES);
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      e     = drv_exp;
      e.acc = cyc;
      sb.push_back(e);
      acc_now = 1'b1;
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    snap_s     = bus.s;
    snap_f     = {bus.c_out, bus.overflow, bus.zero};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(int max_cyc);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < max_cyc && sb.size() > 0; i++) step();
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic directed(op_e op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                          logic [WIDTH-1:0] s_exp, logic c, logic ov, logic z);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b1;
    drv_exp.s          = s_exp;
    drv_exp.f.c_out    = c;
    drv_exp.f.overflow = ov;
    drv_exp.f.zero     = z;
    lat_mode = 1'b1;
    step();
    drain(20);
    lat_mode = 1'b0;
  endtask

  initial begin
    int accepted;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    lat_mode      = 1'b0;
    prev_stall    = 1'b0;
    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_s", bus.s, 0);
    check("rst_flags", {bus.c_out, bus.overflow, bus.zero}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_in_ready", bus.in_ready, 1);

    directed(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001,
             SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed(OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed(OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    directed(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed(OP_SUB, 32'h8000_0000, 32'h0000_0001,
             SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Random stream: a fresh op every cycle, dropped by the bench when not accepted.
    accepted = 0;
    for (int g = 0; g < 500 && accepted < 16; g++) begin
      bus.in_valid  = ($urandom_range(0, 4) != 0);
      bus.op        = op_e'($urandom_range(0, 1));
      bus.a         = pick();
      bus.b         = pick();
      bus.out_ready = $urandom_range(0, 1);
      drv_exp       = model(bus.op, bus.a, bus.b);
      step();
      if (acc_now) accepted++;
    end
    check("rand_accepted", accepted, 16);
    drain(40);

    // Three ops in flight with the output stalled, then reset mid-cycle.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = OP_ADD;
      bus.a        = 32'(i + 1);
      bus.b        = 32'd10;
      drv_exp      = model(bus.op, bus.a, bus.b);
      step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) step();
    check("pre_rst_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_s", bus.s, 0);
    check("mid_rst_flags", {bus.c_out, bus.overflow, bus.zero}, 0);
    sb.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    check("rel_out_valid", bus.out_valid, 0);
    directed(OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pipelined_addsub
